window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/window_gen_pkg.sv | 18 +
 rtl/window_gen.sv | 83 ++++++++
 tb/tb_window_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_pkg.sv
// Shared types and window geometry for the 3x3 window generator.
package window_gen_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WIN_ROWS = 3;
   localparam int WIN_COLS = 3;
   localparam int WIN_PIX  = WIN_ROWS * WIN_COLS;

   // Pixel slot of (row, col) in the row-major window, top-left first.
   function automatic int win_idx(input int row, input int col);
      return row * WIN_COLS + col;
   endfunction

endpackage

// File: rtl/window_gen.sv
// Builds 3x3 pixel windows from a stream of 3-pixel columns.
// Windows never straddle a line boundary.
module window_gen
   import window_gen_pkg::*;
#(
   parameter int LINE_WIDTH = 1280,
   parameter int DATA_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   input  logic [WIN_ROWS*DATA_WIDTH-1:0]      in_data,
   output logic                                out_valid,
   output logic [WIN_PIX*DATA_WIDTH-1:0]       out_data,
   output logic [$clog2(LINE_WIDTH)-1:0]       out_col,
   output logic                                out_eol
);

   localparam int CW = $clog2(LINE_WIDTH);
   localparam int PW = WIN_ROWS * DATA_WIDTH;
   localparam logic [CW-1:0] LAST = CW'(LINE_WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   if (LINE_WIDTH < 3) begin : g_bad_width
      $fatal(1, "window_gen: LINE_WIDTH must be at least 3");
   end

   logic [PW-1:0] c0, c1, c2;
   logic [CW-1:0] col;
   state_t        state;
   logic [PW-1:0] win_col [WIN_COLS];

   always_ff @(posedge clk) begin
      if (rst) begin
         c0        <= '0;
         c1        <= '0;
         c2        <= '0;
         col       <= '0;
         state     <= FILL;
         out_valid <= 1'b0;
         out_col   <= '0;
         out_eol   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_col   <= '0;
         out_eol   <= 1'b0;
         if (in_valid) begin
            c0  <= c1;
            c1  <= c2;
            c2  <= in_data;
            col <= (col == LAST) ? '0 : col + ONE;
            unique case (state)
               FILL: if (col == ONE) state <= RUN;
               RUN:  if (col == LAST) state <= FILL;
            endcase
            // RUN holds exactly for columns 2..LINE_WIDTH-1 of a line.
            if (state == RUN) begin
               out_valid <= 1'b1;
               out_col   <= col - ONE;
               out_eol   <= (col == LAST);
            end
         end
      end
   end

   assign win_col[0] = c0;
   assign win_col[1] = c1;
   assign win_col[2] = c2;

   // Window is taken from the column registers, gated by the registered valid.
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
               out_data[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] =
                  win_col[c][r*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen with LINE_WIDTH=8, DATA_WIDTH=8.
// Expected outputs are queued per driven cycle and popped one cycle later.
module tb_window_gen;

   localparam int LW = 8;
   localparam int DW = 8;
   localparam int CW = $clog2(LW);

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic [3*DW-1:0] in_data;
   logic           out_valid;
   logic [9*DW-1:0] out_data;
   logic [CW-1:0]  out_col;
   logic           out_eol;

   window_gen #(
      .LINE_WIDTH(LW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_col  (out_col),
      .out_eol  (out_eol)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic           v;
      logic [CW-1:0]  col;
      logic           eol;
      logic [9*DW-1:0] data;
   } exp_t;

   typedef struct {
      int   x;
      logic ev;
      int   ecol;
      logic eeol;
   } vec_t;

   exp_t            q[$];
   logic [3*DW-1:0] m_cols [LW];
   int              m_pos;
   int              n_chk;
   int              n_fail;
   int              n_win;
   bit              cap;
   logic [9*DW-1:0] first_win;
   string           tag;
   vec_t            tab [8];

   function automatic logic [3*DW-1:0] px(input int x);
      return {8'(x + 32), 8'(x + 16), 8'(x)};
   endfunction

   task automatic check_out();
      exp_t e;
      if (q.size() == 0) return;
      e = q.pop_front();
      n_chk++;
      if ({out_valid, out_col, out_eol, out_data} !== e) begin
         n_fail++;
         $display("FAIL %s: got v=%0b col=%0d eol=%0b data=%h, want v=%0b col=%0d eol=%0b data=%h",
                  tag, out_valid, out_col, out_eol, out_data,
                  e.v, e.col, e.eol, e.data);
      end
      if (out_valid === 1'b1) begin
         n_win++;
         if (cap) begin
            first_win = out_data;
            cap = 1'b0;
         end
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [3*DW-1:0] d,
                       input bit use_tab, input logic tv, input int tcol,
                       input logic teol);
      exp_t e;
      @(negedge clk);
      check_out();
      rst      = r;
      in_valid = v;
      in_data  = d;
      e = '0;
      if (r) begin
         m_pos = 0;
      end else if (v) begin
         m_cols[m_pos] = d;
         if (m_pos >= 2) begin
            e.v   = 1'b1;
            e.col = CW'(m_pos - 1);
            e.eol = (m_pos == LW - 1);
            for (int rr = 0; rr < 3; rr++)
               for (int cc = 0; cc < 3; cc++)
                  e.data[(rr*3 + cc)*DW +: DW] = m_cols[m_pos - 2 + cc][rr*DW +: DW];
         end
         m_pos = (m_pos + 1) % LW;
      end
      if (use_tab) begin
         e.v   = tv;
         e.col = CW'(tcol);
         e.eol = teol;
         if (!tv) e.data = '0;
      end
      q.push_back(e);
   endtask

   task automatic go(input logic r, input logic v, input logic [3*DW-1:0] d);
      step(r, v, d, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic run_table(input bit gaps);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, px(tab[i].x), 1'b1, tab[i].ev, tab[i].ecol, tab[i].eeol);
         if (gaps) step(1'b0, 1'b0, px(99), 1'b1, 1'b0, 0, 1'b0);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      n_win  = 0;
      m_pos  = 0;
      cap    = 1'b0;
      first_win = '0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

      tab[0] = '{0, 1'b0, 0, 1'b0};
      tab[1] = '{1, 1'b0, 0, 1'b0};
      tab[2] = '{2, 1'b1, 1, 1'b0};
      tab[3] = '{3, 1'b1, 2, 1'b0};
      tab[4] = '{4, 1'b1, 3, 1'b0};
      tab[5] = '{5, 1'b1, 4, 1'b0};
      tab[6] = '{6, 1'b1, 5, 1'b0};
      tab[7] = '{7, 1'b1, 6, 1'b1};

      tag = "reset";
      repeat (3) go(1'b1, 1'b0, '0);

      tag = "line_cont";
      n_win = 0;
      cap = 1'b1;
      run_table(1'b0);
      go(1'b0, 1'b0, '0);
      chk_int("line_cont_windows", n_win, 6);
      n_chk++;
      if (first_win !== 72'h22_21_20_12_11_10_02_01_00) begin
         n_fail++;
         $display("FAIL first_window: got %h, want %h", first_win,
                  72'h22_21_20_12_11_10_02_01_00);
      end

      tag = "two_lines";
      n_win = 0;
      for (int i = 0; i < 16; i++) go(1'b0, 1'b1, px(i % 8));
      go(1'b0, 1'b0, '0);
      chk_int("two_lines_windows", n_win, 12);

      tag = "toggled";
      n_win = 0;
      run_table(1'b1);
      go(1'b0, 1'b0, '0);
      chk_int("toggled_windows", n_win, 6);

      tag = "rst_midline";
      for (int i = 0; i < 5; i++) go(1'b0, 1'b1, px(i + 50));
      go(1'b1, 1'b1, px(55));
      n_win = 0;
      run_table(1'b0);
      go(1'b0, 1'b0, '0);
      chk_int("rst_midline_windows", n_win, 6);

      tag = "rst_hold";
      for (int i = 0; i < 3; i++) go(1'b0, 1'b1, px(i + 70));
      for (int i = 0; i < 5; i++) go(1'b1, 1'b1, px(i + 80));
      n_win = 0;
      run_table(1'b0);
      go(1'b0, 1'b0, '0);
      chk_int("rst_hold_windows", n_win, 6);

      tag = "random";
      n_win = 0;
      for (int ln = 0; ln < 100; ln++) begin
         for (int x = 0; x < LW; x++) begin
            repeat ($urandom_range(0, 2)) go(1'b0, 1'b0, 24'($urandom()));
            go(1'b0, 1'b1, 24'($urandom()));
         end
      end
      go(1'b0, 1'b0, '0);
      go(1'b0, 1'b0, '0);
      chk_int("random_windows", n_win, 600);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
